// File: rtl/conv_proc_elem_pkg.sv
// Shared types, default widths and the saturating add used by the conv PE.
// The saturating add is only instantiated when PROC_ELEM_SAT_EN is defined.
package proc_elem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int SAT_W      = 64;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_DATA_W-1:0] weight_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;
  typedef logic signed [SAT_W-1:0]      wide_t;

  // Adds two sign-extended operands and clamps the result to a signed acc_w-bit range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int acc_w,
                                    output logic sat);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    one     = 1;
    sum     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi      = (one <<< (acc_w - 1)) - one;
    lo      = -(one <<< (acc_w - 1));
    sat     = 1'b0;
    sat_add = sum[SAT_W-1:0];
    if (sum > hi) begin
      sat     = 1'b1;
      sat_add = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      sat     = 1'b1;
      sat_add = lo[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/conv_proc_elem_if.sv
// Sample/partial-sum link of one conv PE: master drives the stream, slave is the PE.
interface conv_proc_elem_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic                     valid_in;
  logic signed [DATA_W-1:0] x_in;
  logic signed [ACC_W-1:0]  y_in;
  logic signed [DATA_W-1:0] weight;
  logic                     weight_ld;
  logic signed [DATA_W-1:0] x_out;
  logic signed [ACC_W-1:0]  y_out;
  logic                     valid_out;
  logic                     y_sat;

  modport master (
    output valid_in, x_in, y_in, weight, weight_ld,
    input  x_out, y_out, valid_out, y_sat
  );

  modport slave (
    input  valid_in, x_in, y_in, weight, weight_ld,
    output x_out, y_out, valid_out, y_sat
  );
endinterface

// File: rtl/conv_proc_elem_mac.sv
// pe_mac: combinational y_in + sext(w * x). PROC_ELEM_SAT_EN selects clamping
// to the accumulator range; otherwise the sum wraps modulo 2^ACC_W.
module pe_mac
  import proc_elem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [ACC_W-1:0]  y_in,
  output logic signed [ACC_W-1:0]  y_sum,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
`ifdef PROC_ELEM_SAT_EN
  wide_t                      wide_sum;
`endif

  always_comb begin
    prod     = (2*DATA_W)'(w) * (2*DATA_W)'(x);
    prod_ext = ACC_W'(prod);
`ifdef PROC_ELEM_SAT_EN
    wide_sum = sat_add(SAT_W'(y_in), SAT_W'(prod_ext), ACC_W, sat);
    y_sum    = wide_sum[ACC_W-1:0];
`else
    y_sum    = y_in + prod_ext;
    sat      = 1'b0;
`endif
  end

endmodule

// File: rtl/conv_proc_elem.sv
// Systolic 1-D convolution PE: stationary weight, x forwarded through X_DELAY
// valid-gated stages, y_out = y_in + w*x. Saturation via PROC_ELEM_SAT_EN (see pe_mac).
module conv_proc_elem
  import proc_elem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int X_DELAY = 1
) (
  input logic             clk,
  input logic             rst,
  conv_proc_elem_if.slave pe
);

  logic signed [DATA_W-1:0] w_q, w_d;
  logic signed [DATA_W-1:0] x_q [X_DELAY];
  logic signed [DATA_W-1:0] x_d [X_DELAY];
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     valid_q, valid_d;
  logic                     sat_q, sat_d;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_sat;

  // The MAC always sees the registered weight, so a coincident load takes effect next cycle.
  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .w     (w_q),
    .x     (pe.x_in),
    .y_in  (pe.y_in),
    .y_sum (mac_sum),
    .sat   (mac_sat)
  );

  always_comb begin
    w_d     = pe.weight_ld ? pe.weight : w_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = 1'b0;
    sat_d   = sat_q;
    if (pe.valid_in) begin
      x_d[0] = pe.x_in;
      for (int i = 1; i < X_DELAY; i++) begin
        x_d[i] = x_q[i-1];
      end
      y_d     = mac_sum;
      valid_d = 1'b1;
      sat_d   = sat_q | mac_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      for (int i = 0; i < X_DELAY; i++) begin
        x_q[i] <= '0;
      end
      y_q     <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      w_q     <= w_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign pe.x_out     = x_q[X_DELAY-1];
  assign pe.y_out     = y_q;
  assign pe.valid_out = valid_q;
  assign pe.y_sat     = sat_q;

endmodule

// File: tb/tb_conv_proc_elem.sv
// Directed bench for conv_proc_elem: X_DELAY=1 and X_DELAY=2 instances share one stimulus.
module tb_conv_proc_elem;
  import proc_elem_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    valid_in;
  logic    weight_ld;
  sample_t x_in;
  weight_t weight;
  acc_t    y_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_proc_elem_if #(.DATA_W(8), .ACC_W(24)) if1 ();
  conv_proc_elem_if #(.DATA_W(8), .ACC_W(24)) if2 ();

  assign if1.valid_in  = valid_in;
  assign if1.x_in      = x_in;
  assign if1.y_in      = y_in;
  assign if1.weight    = weight;
  assign if1.weight_ld = weight_ld;
  assign if2.valid_in  = valid_in;
  assign if2.x_in      = x_in;
  assign if2.y_in      = y_in;
  assign if2.weight    = weight;
  assign if2.weight_ld = weight_ld;

  conv_proc_elem #(.DATA_W(8), .ACC_W(24), .X_DELAY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .pe  (if1.slave)
  );

  conv_proc_elem #(.DATA_W(8), .ACC_W(24), .X_DELAY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .pe  (if2.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    weight_ld = 1'b0;
    x_in      = '0;
    y_in      = '0;
    weight    = '0;
  endtask

  task automatic load_weight(input weight_t w);
    idle();
    weight_ld = 1'b1;
    weight    = w;
    step();
    weight_ld = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst       = 1'b1;
    valid_in  = 1'b1;
    weight_ld = 1'b1;
    weight    = 8'sd9;
    x_in      = 8'sd7;
    y_in      = 24'sd7;
    step();
    step();
    idle();
    rst = 1'b0;
    checks++; if (if1.y_out !== 24'sd0) begin errors++; $display("FAIL reset_y1 got=%0d exp=0", if1.y_out); end
    checks++; if (if1.x_out !== 8'sd0) begin errors++; $display("FAIL reset_x1 got=%0d exp=0", if1.x_out); end
    checks++; if (if1.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid1 got=%b exp=0", if1.valid_out); end
    checks++; if (if1.y_sat !== 1'b0) begin errors++; $display("FAIL reset_sat1 got=%b exp=0", if1.y_sat); end
    checks++; if (if2.x_out !== 8'sd0) begin errors++; $display("FAIL reset_x2 got=%0d exp=0", if2.x_out); end
    // Weight must also have cleared: a sample now passes y_in through unchanged.
    valid_in = 1'b1; x_in = 8'sd5; y_in = 24'sd3;
    step();
    idle();
    checks++; if (if1.y_out !== 24'sd3) begin errors++; $display("FAIL reset_w0 got=%0d exp=3", if1.y_out); end
  endtask

  task automatic test_basic();
    load_weight(8'sd10);
    valid_in = 1'b1; x_in = 8'sd5; y_in = 24'sd15;
    step();
    idle();
    checks++; if (if1.y_out !== 24'sd65) begin errors++; $display("FAIL basic_y got=%0d exp=65", if1.y_out); end
    checks++; if (if1.x_out !== 8'sd5) begin errors++; $display("FAIL basic_x got=%0d exp=5", if1.x_out); end
    checks++; if (if1.valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", if1.valid_out); end
    checks++; if (if2.y_out !== 24'sd65) begin errors++; $display("FAIL basic_y2 got=%0d exp=65", if2.y_out); end
    step();
    checks++; if (if1.valid_out !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%b exp=0", if1.valid_out); end
    checks++; if (if1.y_out !== 24'sd65) begin errors++; $display("FAIL bubble_y_hold got=%0d exp=65", if1.y_out); end
    checks++; if (if1.x_out !== 8'sd5) begin errors++; $display("FAIL bubble_x_hold got=%0d exp=5", if1.x_out); end
  endtask

  task automatic test_stream();
    sample_t xs  [5] = '{8'sd0, 8'sd16, 8'sd51, 8'sd3, 8'sd4};
    acc_t    ys  [5] = '{24'sd14, 24'sd1, 24'sd20, 24'sd4, 24'sd4};
    acc_t    exy [5] = '{24'sd14, 24'sd161, 24'sd530, 24'sd34, 24'sd44};
    sample_t ex2 [5] = '{8'sd5, 8'sd0, 8'sd16, 8'sd51, 8'sd3};
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; x_in = xs[i]; y_in = ys[i];
      step();
      checks++; if (if1.y_out !== exy[i]) begin errors++; $display("FAIL stream_y[%0d] got=%0d exp=%0d", i, if1.y_out, exy[i]); end
      checks++; if (if1.x_out !== xs[i]) begin errors++; $display("FAIL stream_x1[%0d] got=%0d exp=%0d", i, if1.x_out, xs[i]); end
      checks++; if (if2.x_out !== ex2[i]) begin errors++; $display("FAIL stream_x2[%0d] got=%0d exp=%0d", i, if2.x_out, ex2[i]); end
      checks++; if (if1.valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, if1.valid_out); end
    end
    idle();
  endtask

  task automatic test_neg_weight();
    load_weight(-8'sd3);
    valid_in = 1'b1; x_in = 8'sd4; y_in = 24'sd4;
    step();
    idle();
    checks++; if (if1.y_out !== -24'sd8) begin errors++; $display("FAIL neg_weight got=%0d exp=-8", if1.y_out); end
  endtask

  task automatic test_weight_change();
    load_weight(8'sd10);
    valid_in = 1'b1; weight_ld = 1'b1; weight = 8'sd2; x_in = 8'sd3; y_in = 24'sd0;
    step();
    weight_ld = 1'b0;
    checks++; if (if1.y_out !== 24'sd30) begin errors++; $display("FAIL wchg_old got=%0d exp=30", if1.y_out); end
    step();
    idle();
    checks++; if (if1.y_out !== 24'sd6) begin errors++; $display("FAIL wchg_new got=%0d exp=6", if1.y_out); end
  endtask

  task automatic test_overflow();
    load_weight(8'sd127);
    valid_in = 1'b1; x_in = 8'sd127; y_in = 24'sd8388600;
    step();
    idle();
`ifdef PROC_ELEM_SAT_EN
    checks++; if (if1.y_out !== 24'sd8388607) begin errors++; $display("FAIL ovf_sat_y got=%0d exp=8388607", if1.y_out); end
    checks++; if (if1.y_sat !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag got=%b exp=1", if1.y_sat); end
`else
    checks++; if (if1.y_out !== -24'sd8372487) begin errors++; $display("FAIL ovf_wrap_y got=%0d exp=-8372487", if1.y_out); end
    checks++; if (if1.y_sat !== 1'b0) begin errors++; $display("FAIL ovf_wrap_flag got=%b exp=0", if1.y_sat); end
`endif
    // In-range sample afterwards: flag must be sticky (or stay 0 without saturation).
    valid_in = 1'b1; x_in = 8'sd0; y_in = 24'sd1;
    step();
    idle();
    checks++; if (if1.y_out !== 24'sd1) begin errors++; $display("FAIL ovf_after_y got=%0d exp=1", if1.y_out); end
`ifdef PROC_ELEM_SAT_EN
    checks++; if (if1.y_sat !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", if1.y_sat); end
`else
    checks++; if (if1.y_sat !== 1'b0) begin errors++; $display("FAIL ovf_sticky got=%b exp=0", if1.y_sat); end
`endif
  endtask

  task automatic test_reset_mid();
    load_weight(8'sd5);
    valid_in = 1'b1; x_in = 8'sd7; y_in = 24'sd1;
    step();
    rst = 1'b1; weight_ld = 1'b1; weight = 8'sd3; x_in = 8'sd9; y_in = 24'sd9;
    step();
    rst = 1'b0; idle();
    checks++; if (if1.y_out !== 24'sd0) begin errors++; $display("FAIL rstmid_y got=%0d exp=0", if1.y_out); end
    checks++; if (if1.x_out !== 8'sd0) begin errors++; $display("FAIL rstmid_x1 got=%0d exp=0", if1.x_out); end
    checks++; if (if2.x_out !== 8'sd0) begin errors++; $display("FAIL rstmid_x2 got=%0d exp=0", if2.x_out); end
    checks++; if (if1.valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", if1.valid_out); end
    checks++; if (if1.y_sat !== 1'b0) begin errors++; $display("FAIL rstmid_sat got=%b exp=0", if1.y_sat); end
    valid_in = 1'b1; x_in = 8'sd6; y_in = 24'sd100;
    step();
    checks++; if (if1.y_out !== 24'sd100) begin errors++; $display("FAIL rstmid_w0 got=%0d exp=100", if1.y_out); end
    checks++; if (if1.x_out !== 8'sd6) begin errors++; $display("FAIL rstmid_x1b got=%0d exp=6", if1.x_out); end
    checks++; if (if2.x_out !== 8'sd0) begin errors++; $display("FAIL rstmid_x2b got=%0d exp=0", if2.x_out); end
    x_in = 8'sd8; y_in = -24'sd5;
    step();
    checks++; if (if2.y_out !== -24'sd5) begin errors++; $display("FAIL rstmid_y2 got=%0d exp=-5", if2.y_out); end
    checks++; if (if2.x_out !== 8'sd6) begin errors++; $display("FAIL lag2_a got=%0d exp=6", if2.x_out); end
    idle();
    step();
    checks++; if (if2.x_out !== 8'sd6) begin errors++; $display("FAIL lag2_bubble got=%0d exp=6", if2.x_out); end
    valid_in = 1'b1; x_in = 8'sd2; y_in = 24'sd0;
    step();
    idle();
    checks++; if (if2.x_out !== 8'sd8) begin errors++; $display("FAIL lag2_b got=%0d exp=8", if2.x_out); end
    checks++; if (if1.x_out !== 8'sd2) begin errors++; $display("FAIL lag1_b got=%0d exp=2", if1.x_out); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_stream();
    test_neg_weight();
    test_weight_change();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
